// File: rtl/embedding_pkg.sv
// Shared types and helpers for the embedding weight streamer.
// Holds the FSM state encoding and a clog2 that never returns zero.
package embedding_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/embedding_wt_mem.sv
// Register-array weight store: one write port, LANES-wide combinational read.
// Contents clear asynchronously on reset.
module embedding_wt_mem
    import embedding_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    parameter int LANES  = 2,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BEAT_W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [BEAT_W-1:0]       rd_beat_i,
    output logic [LANES*DATA_W-1:0] rd_data_o
);

    localparam int IDX_W = clog2_min1(DEPTH);

    logic [DATA_W-1:0] weights_q [DEPTH];
    logic [IDX_W-1:0]  rd_idx;

    // Addresses past the end of the array are dropped rather than aliased.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                weights_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < DEPTH)) begin
            weights_q[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_idx    = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_idx = IDX_W'(int'(rd_beat_i) * LANES + k);
            rd_data_o[k*DATA_W +: DATA_W] = weights_q[rd_idx];
        end
    end

endmodule

// File: rtl/embedding_wt_streamer.sv
// Loadable weight store that streams LANES weights per beat, repeating the
// whole set num_pass times per start command, over a valid/ready port.
module embedding_wt_streamer
    import embedding_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    parameter int LANES  = 2,
    parameter int PASS_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    input  logic [PASS_W-1:0]       num_pass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic                    out_final,
    output logic                    busy,
    output logic                    done
);

    localparam int BEATS  = DEPTH / LANES;
    localparam int BEAT_W = clog2_min1(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [PASS_W-1:0]       pass_q, pass_d;
    logic [PASS_W-1:0]       npass_q, npass_d;
    logic                    valid_q, valid_d;
    logic [LANES*DATA_W-1:0] data_q, data_d;
    logic                    last_q, last_d;
    logic                    final_q, final_d;
    logic                    done_q, done_d;
    logic                    load;
    logic                    mem_we;
    logic [LANES*DATA_W-1:0] rd_data;

    // A start in the same cycle wins over a write.
    assign mem_we = (state_q == IDLE) && wr_en && !start;

    embedding_wt_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .BEAT_W (BEAT_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .we_i      (mem_we),
        .waddr_i   (wr_addr),
        .wdata_i   (wr_data),
        .rd_beat_i (beat_d),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pass_d  = pass_q;
        npass_d = npass_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_pass != '0) begin
                        state_d = STREAM;
                        npass_d = num_pass;
                        beat_d  = '0;
                        pass_d  = '0;
                        valid_d = 1'b1;
                        load    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (valid_q && out_ready) begin
                    if (beat_q != LAST_BEAT) begin
                        beat_d = beat_q + BEAT_W'(1);
                        load   = 1'b1;
                    end else if (pass_q != npass_q - PASS_W'(1)) begin
                        beat_d = '0;
                        pass_d = pass_q + PASS_W'(1);
                        load   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: refill on every accepted beat, otherwise hold.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        final_d = final_q;
        if (load) begin
            data_d  = rd_data;
            last_d  = (beat_d == LAST_BEAT);
            final_d = last_d && (pass_d == npass_d - PASS_W'(1));
        end else if (!valid_d) begin
            last_d  = 1'b0;
            final_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            pass_q  <= '0;
            npass_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            final_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pass_q  <= pass_d;
            npass_q <= npass_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            final_q <= final_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_final = final_q;
    assign busy      = (state_q == STREAM);
    assign done      = done_q;

endmodule

// File: tb/tb_embedding_wt_streamer.sv
// Scoreboard bench for embedding_wt_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_embedding_wt_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic [7:0]  num_pass;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_final;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        f;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem_m [16];
    int          n_total = 0;
    int          n_pass  = 0;

    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [17:0] pbeat = '0;

    embedding_wt_streamer #(
        .DATA_W (8),
        .DEPTH  (16),
        .LANES  (2),
        .PASS_W (8),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .num_pass  (num_pass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_final (out_final),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int np);
        exp_t e;
        for (int p = 0; p < np; p++) begin
            for (int b = 0; b < 8; b++) begin
                e.d = {mem_m[2*b+1], mem_m[2*b]};
                e.l = (b == 7);
                e.f = (b == 7) && (p == np - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < 16) mem_m[a] = d;
    endtask

    // mode: 0 plain, 1 write mid-stream, 2 start mid-stream, 3 write with start
    task automatic run_cmd(input int np, input bit bp, input int mode, input logic [15:0] first);
        int n;
        push_exp(np);
        start    = 1'b1;
        num_pass = 8'(np);
        if (mode == 3) begin
            wr_en   = 1'b1;
            wr_addr = 5'd3;
            wr_data = 8'hEE;
        end
        tick();
        start    = 1'b0;
        wr_en    = 1'b0;
        num_pass = 8'd0;
        n = 1;
        check("first_beat", {15'd0, out_valid, out_data}, {15'd0, 1'b1, first});
        while (!done && n < 1000) begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            if (mode == 1 && n == 2) begin
                wr_en   = 1'b1;
                wr_addr = 5'd0;
                wr_data = 8'hAA;
            end else if (mode == 2 && n == 3) begin
                start    = 1'b1;
                num_pass = 8'd5;
            end else begin
                wr_en    = 1'b0;
                start    = 1'b0;
                num_pass = 8'd0;
            end
            tick();
            n++;
        end
        out_ready = 1'b1;
        wr_en     = 1'b0;
        start     = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        if (!bp) check("done_cycle", n, 8 * np + 1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("valid_in_done", {31'd0, out_valid}, 32'd0);
        tick();
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("scoreboard_drained", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pv && !pr) begin
                check("valid_held_in_stall", {31'd0, out_valid}, 32'd1);
                check("stall_stable", {14'd0, out_data, out_last, out_final}, {14'd0, pbeat});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got %h expected no beat", out_data);
                end else begin
                    e = q.pop_front();
                    check("beat", {14'd0, out_data, out_last, out_final}, {14'd0, e.d, e.l, e.f});
                end
            end
        end
        pv    = out_valid && !rst;
        pr    = out_ready;
        pbeat = {out_data, out_last, out_final};
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        num_pass  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_data",  {16'd0, out_data}, 32'd0);
        check("rst_last",  {30'd0, out_last, out_final}, 32'd0);
        rst = 1'b0;
        tick();

        run_cmd(1, 1'b0, 0, 16'h0000);

        for (int i = 0; i < 16; i++) wr(i, 8'(i + 1));
        run_cmd(1, 1'b0, 0, 16'h0201);
        run_cmd(3, 1'b0, 0, 16'h0201);
        run_cmd(1, 1'b1, 0, 16'h0201);

        start    = 1'b1;
        num_pass = 8'd0;
        tick();
        start = 1'b0;
        check("zero_pass_done",  {31'd0, done}, 32'd1);
        check("zero_pass_valid", {31'd0, out_valid}, 32'd0);
        check("zero_pass_busy",  {31'd0, busy}, 32'd0);
        tick();
        check("zero_pass_done_clear", {31'd0, done}, 32'd0);

        run_cmd(2, 1'b0, 1, 16'h0201);
        run_cmd(1, 1'b0, 0, 16'h0201);
        wr(16, 8'h55);
        run_cmd(1, 1'b0, 0, 16'h0201);
        run_cmd(1, 1'b0, 2, 16'h0201);
        run_cmd(1, 1'b0, 3, 16'h0201);

        push_exp(1);
        start    = 1'b1;
        num_pass = 8'd1;
        tick();
        start    = 1'b0;
        num_pass = 8'd0;
        tick();
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        check("abort_valid_async", {31'd0, out_valid}, 32'd0);
        check("abort_beats_left", q.size(), 5);
        q.delete();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= done;
            tick();
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        run_cmd(1, 1'b0, 0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
